// File: rtl/click_rx_sync.sv
// click_rx_sync: clocked receiver at the output end of a 2-phase click pipeline.
// It synchronises the incoming request, captures the bundled data, returns the ack
// transition and buffers tokens in a first-word-fall-through FIFO.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// IDLE       | no token waiting, or a pending token is captured this edge
// WAIT_SPACE | a token is pending but the FIFO is full; hold the ack back
//
// reset_n asserts asynchronously; its release is expected to be clk-synchronous.
// On release in_req is normally 0 because the upstream pipeline shares reset_n;
// if it is 1, that is treated as a fresh token.
module click_rx_sync #(
    parameter int DW          = 2,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_req,
    input  logic [DW-1:0]          in_data,
    output logic                   in_ack,
    output logic                   out_valid,
    output logic [DW-1:0]          out_data,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        IDLE       = 1'b0,
        WAIT_SPACE = 1'b1
    } state_t;

    state_t              r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                r_ack;
    logic [DW-1:0]       r_mem [DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;

    logic                w_req_s;
    logic                w_pending;
    logic                w_full;
    logic                w_push;
    logic                w_pop;

    // Full is judged on the registered count only, so a pop never lets a push
    // through on the same edge; the held token goes in one edge later.
    assign w_req_s   = r_sync[SYNC_STAGES-1];
    assign w_pending = (w_req_s != r_ack);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_push    = w_pending & ~w_full;
    assign w_pop     = (r_count != '0) & out_ready;

    assign in_ack     = r_ack;
    assign out_valid  = (r_count != '0);
    assign out_data   = r_mem[r_rd_ptr];
    assign fifo_count = r_count;

    // Synchronise the 2-phase request; the bundled data is never synchronised.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], in_req};
        end
    end

    // Capture control: toggle the ack on every accepted token, stall while full.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_push) begin
                        r_ack <= ~r_ack;
                    end else if (w_pending) begin
                        r_state <= WAIT_SPACE;
                    end
                end
                WAIT_SPACE: begin
                    if (w_push) begin
                        r_ack   <= ~r_ack;
                        r_state <= IDLE;
                    end else if (!w_pending) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Token FIFO: write at tail on capture, advance head on pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= in_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
